// File: rtl/ap_kernel_launcher.sv
// Argument collector and launcher for a block-level (ap_ctrl_hs style) kernel.
// Define AP_KERNEL_LAUNCHER_PREFETCH_EN to let empty slots fill while a launch is in flight.
module ap_kernel_launcher #(
    parameter int DATA_W   = 8,
    parameter int RESULT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   in0_data,
    input  logic                in0_valid,
    output logic                in0_ready,
    input  logic [DATA_W-1:0]   in1_data,
    input  logic                in1_valid,
    output logic                in1_ready,
    output logic [RESULT_W-1:0] out0_data,
    output logic                out0_valid,
    input  logic                out0_ready,
    output logic                ap_start,
    input  logic                ap_ready,
    input  logic                ap_done,
    output logic [DATA_W-1:0]   ap_arg0,
    output logic [DATA_W-1:0]   ap_arg1,
    input  logic [RESULT_W-1:0] ap_ret
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t              state;
    logic                slot0_full;
    logic                slot1_full;
    logic [DATA_W-1:0]   slot0_data;
    logic [DATA_W-1:0]   slot1_data;
    logic [RESULT_W-1:0] result;
    logic                start_q;
    logic                valid_q;
    logic                take0;
    logic                take1;
    logic                both_full;

    // Ready is a function of registered state only; slots are always full in START,
    // so the launch edge never accepts a token even with prefetch enabled.
`ifdef AP_KERNEL_LAUNCHER_PREFETCH_EN
    assign in0_ready = !slot0_full;
    assign in1_ready = !slot1_full;
`else
    assign in0_ready = !slot0_full && (state == IDLE);
    assign in1_ready = !slot1_full && (state == IDLE);
`endif

    assign take0     = in0_valid && in0_ready;
    assign take1     = in1_valid && in1_ready;
    // Counts tokens landing on this edge so ap_start rises the cycle after the last argument.
    assign both_full = (slot0_full || take0) && (slot1_full || take1);

    assign ap_start   = start_q;
    assign out0_valid = valid_q;
    assign out0_data  = result;
    assign ap_arg0    = slot0_data;
    assign ap_arg1    = slot1_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            slot0_full <= 1'b0;
            slot1_full <= 1'b0;
            slot0_data <= '0;
            slot1_data <= '0;
            result     <= '0;
            start_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            if (take0) begin
                slot0_data <= in0_data;
                slot0_full <= 1'b1;
            end
            if (take1) begin
                slot1_data <= in1_data;
                slot1_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (both_full) begin
                        state   <= START;
                        start_q <= 1'b1;
                    end
                end
                START: begin
                    if (ap_ready) begin
                        state      <= RUN;
                        start_q    <= 1'b0;
                        slot0_full <= 1'b0;
                        slot1_full <= 1'b0;
                    end
                end
                RUN: begin
                    if (ap_done) begin
                        result  <= ap_ret;
                        valid_q <= 1'b1;
                        state   <= OUT;
                    end
                end
                OUT: begin
                    if (out0_ready) begin
                        valid_q <= 1'b0;
                        if (both_full) begin
                            state   <= START;
                            start_q <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ap_kernel_launcher.sv
// Bench for ap_kernel_launcher: directed scenarios plus random traffic against a token-queue model.
// Honours AP_KERNEL_LAUNCHER_PREFETCH_EN where the expected timing differs.
module tb_ap_kernel_launcher;

    localparam int DATA_W   = 8;
    localparam int RESULT_W = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [DATA_W-1:0]   in0_data;
    logic                in0_valid;
    logic                in0_ready;
    logic [DATA_W-1:0]   in1_data;
    logic                in1_valid;
    logic                in1_ready;
    logic [RESULT_W-1:0] out0_data;
    logic                out0_valid;
    logic                out0_ready;
    logic                ap_start;
    logic                ap_ready;
    logic                ap_done;
    logic [DATA_W-1:0]   ap_arg0;
    logic [DATA_W-1:0]   ap_arg1;
    logic [RESULT_W-1:0] ap_ret;

    ap_kernel_launcher #(
        .DATA_W   (DATA_W),
        .RESULT_W (RESULT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in0_data   (in0_data),
        .in0_valid  (in0_valid),
        .in0_ready  (in0_ready),
        .in1_data   (in1_data),
        .in1_valid  (in1_valid),
        .in1_ready  (in1_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .ap_start   (ap_start),
        .ap_ready   (ap_ready),
        .ap_done    (ap_done),
        .ap_arg0    (ap_arg0),
        .ap_arg1    (ap_arg1),
        .ap_ret     (ap_ret)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: accepted tokens, pending results, and a simple kernel.
    logic [DATA_W-1:0]   q0[$];
    logic [DATA_W-1:0]   q1[$];
    logic [RESULT_W-1:0] qres[$];
    bit                  busy;
    int                  cnt;
    int                  lat_cfg;
    bit                  ret_fixed;
    logic [RESULT_W-1:0] ret_val;
    int                  ready_pct;
    int                  ready_block;
    int                  launches;
    int                  delivered;
    bit                  prev_start_wait;
    bit                  prev_out_wait;
    bit                  prev_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge: checks this cycle, models the coming rising edge, advances one cycle.
    task automatic step();
        bit acc0, acc1, done_now, launch_now, stall_start, stall_out;
        if (prev_start_wait) check("start_held", ap_start, 1);
        if (prev_out_wait)   check("valid_held", out0_valid, 1);
        if (prev_done)       check("done_to_valid", out0_valid, 1);
        if (ap_start) begin
            check("start_kernel_idle", busy, 0);
            check("start_has_args", (q0.size() > 0 && q1.size() > 0), 1);
            if (q0.size() > 0) check("ap_arg0", ap_arg0, q0[0]);
            if (q1.size() > 0) check("ap_arg1", ap_arg1, q1[0]);
        end
        if (out0_valid) begin
            check("valid_has_result", qres.size() > 0, 1);
            if (qres.size() > 0) check("out0_data", out0_data, qres[0]);
        end

        acc0        = in0_valid && in0_ready;
        acc1        = in1_valid && in1_ready;
        done_now    = ap_done && busy;
        launch_now  = ap_start && ap_ready;
        stall_start = ap_start && !ap_ready;
        stall_out   = out0_valid && !out0_ready;

        if (out0_valid && out0_ready && qres.size() > 0) begin
            void'(qres.pop_front());
            delivered++;
        end
        if (done_now) begin
            qres.push_back(ap_ret);
            busy = 0;
        end
        if (launch_now) begin
            if (q0.size() > 0) void'(q0.pop_front());
            if (q1.size() > 0) void'(q1.pop_front());
            busy = 1;
            cnt  = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(6, 1));
            launches++;
        end
        if (acc0) q0.push_back(in0_data);
        if (acc1) q1.push_back(in1_data);

        @(posedge clk);
        #1;
        if (acc0) in0_valid = 1'b0;
        if (acc1) in1_valid = 1'b0;
        ap_done = 1'b0;
        if (busy) begin
            cnt--;
            if (cnt == 0) begin
                ap_done = 1'b1;
                ap_ret  = ret_fixed ? ret_val : RESULT_W'($urandom);
            end
        end
        if (ready_block > 0) begin
            ap_ready = 1'b0;
            ready_block--;
        end else begin
            ap_ready = !busy && (int'($urandom_range(99, 0)) < ready_pct);
        end
        prev_start_wait = stall_start;
        prev_out_wait   = stall_out;
        prev_done       = done_now;
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle so only an asynchronous reset clears the outputs in time.
    task automatic do_reset();
        #2;
        rst         = 1'b0;
        in0_valid   = 1'b0;
        in1_valid   = 1'b0;
        ap_done     = 1'b0;
        ap_ready    = 1'b0;
        out0_ready  = 1'b0;
        q0.delete();
        q1.delete();
        qres.delete();
        busy            = 0;
        ready_block     = 0;
        prev_start_wait = 0;
        prev_out_wait   = 0;
        prev_done       = 0;
        launches        = delivered;
        #1;
        check("rst_ap_start", ap_start, 0);
        check("rst_out0_valid", out0_valid, 0);
        check("rst_out0_data", out0_data, 0);
        check("rst_ap_arg0", ap_arg0, 0);
        check("rst_ap_arg1", ap_arg1, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in0_ready", in0_ready, 1);
        check("rst_in1_ready", in1_ready, 1);
        @(negedge clk);
    endtask

    // Completes any half-supplied pair and lets all outstanding work finish.
    task automatic drain();
        int k = 0;
        out0_ready = 1'b1;
        ready_pct  = 100;
        while (k < 300 && (busy || qres.size() != 0 || q0.size() != 0 || q1.size() != 0
                           || in0_valid || in1_valid)) begin
            if (!in0_valid && q0.size() < q1.size()) begin
                in0_valid = 1'b1;
                in0_data  = DATA_W'($urandom);
            end
            if (!in1_valid && q1.size() < q0.size()) begin
                in1_valid = 1'b1;
                in1_data  = DATA_W'($urandom);
            end
            step();
            k++;
        end
        check("drain_within_budget", k < 300, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int l0;
        int d0;
        rst        = 1'b0;
        in0_data   = '0;
        in1_data   = '0;
        in0_valid  = 1'b0;
        in1_valid  = 1'b0;
        out0_ready = 1'b0;
        ap_ready   = 1'b0;
        ap_done    = 1'b0;
        ap_ret     = '0;
        lat_cfg    = 5;
        ret_fixed  = 1;
        ret_val    = '0;
        ready_pct  = 100;
        launches   = 0;
        delivered  = 0;
        @(negedge clk);
        do_reset();

        // Basic transaction: 100 / 7, kernel returns 14 five cycles after launch.
        lat_cfg = 5; ret_fixed = 1; ret_val = 8'd14; ready_pct = 100; out0_ready = 1'b0;
        in0_data = 8'd100; in1_data = 8'd7; in0_valid = 1'b1; in1_valid = 1'b1;
        step();
        check("basic_start", ap_start, 1);
        check("basic_arg0", ap_arg0, 100);
        check("basic_arg1", ap_arg1, 7);
        step();
        check("basic_start_one_cycle", ap_start, 0);
        k = 0;
        while (!out0_valid && k < 20) begin
            step();
            k++;
        end
        check("basic_latency", k, 5);
        check("basic_result", out0_data, 14);
        repeat (3) begin
            step();
            check("basic_hold", out0_valid, 1);
        end
        out0_ready = 1'b1;
        step();
        check("basic_taken", out0_valid, 0);
        drain();

        // Skewed arguments: 9 now, 3 four cycles later.
        do_reset();
        lat_cfg = 2; ready_pct = 100; out0_ready = 1'b1;
        in0_data = 8'd9; in0_valid = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            check("skew_in0_ready_low", in0_ready, 0);
            check("skew_no_start", ap_start, 0);
            if (i == 3) begin
                in1_data  = 8'd3;
                in1_valid = 1'b1;
            end
            step();
        end
        check("skew_start", ap_start, 1);
        check("skew_in0_ready_start", in0_ready, 0);
        check("skew_arg0", ap_arg0, 9);
        check("skew_arg1", ap_arg1, 3);
        drain();

        // Kernel busy: ap_ready low four cycles after ap_start rises.
        do_reset();
        lat_cfg = 2; ready_pct = 100; out0_ready = 1'b1;
        l0 = launches; d0 = delivered;
        in0_data = 8'd33; in1_data = 8'd44; in0_valid = 1'b1; in1_valid = 1'b1;
        ready_block = 4;
        step();
        k = 0;
        while (ap_start && k < 20) begin
            k++;
            step();
        end
        check("busy_start_len", k, 5);
        drain();
        check("busy_single_launch", launches - l0, 1);
        check("busy_single_result", delivered - d0, 1);

        // Back-pressure on the result with the next arguments waiting.
        do_reset();
        lat_cfg = 1; ret_val = 8'h2A; ready_pct = 100; out0_ready = 1'b0;
        in0_data = 8'd1; in1_data = 8'd2; in0_valid = 1'b1; in1_valid = 1'b1;
        step();
        k = 0;
        while (!out0_valid && k < 20) begin
            step();
            k++;
        end
        check("bp_result_seen", out0_valid, 1);
        in0_data = 8'd50; in1_data = 8'd5; in0_valid = 1'b1; in1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_out_data", out0_data, 8'h2A);
            check("bp_no_start", ap_start, 0);
            step();
        end
        out0_ready = 1'b1;
        step();
`ifdef AP_KERNEL_LAUNCHER_PREFETCH_EN
        check("bp_start_after_take", ap_start, 1);
`else
        check("bp_idle_after_take", ap_start, 0);
        check("bp_ready_after_take", in0_ready, 1);
        step();
        check("bp_start_after_accept", ap_start, 1);
`endif
        check("bp_next_arg0", ap_arg0, 50);
        check("bp_next_arg1", ap_arg1, 5);
        drain();

        // Reset while the kernel is running, then a stray completion.
        do_reset();
        lat_cfg = 8; ret_val = 8'h77; ready_pct = 100; out0_ready = 1'b1;
        in0_data = 8'd11; in1_data = 8'd22; in0_valid = 1'b1; in1_valid = 1'b1;
        step();
        step();
        step();
        step();
        do_reset();
        ready_pct = 100; out0_ready = 1'b1;
        ap_done = 1'b1; ap_ret = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_stray_done_ignored", out0_valid, 0);
        end
        lat_cfg = 3; ret_val = 8'd5;
        in0_data = 8'd20; in1_data = 8'd4; in0_valid = 1'b1; in1_valid = 1'b1;
        k = 0;
        step();
        while (!out0_valid && k < 20) begin
            step();
            k++;
        end
        check("rst_next_valid", out0_valid, 1);
        check("rst_next_result", out0_data, 5);
        drain();

        // Random traffic on all handshakes, random kernel latency and results.
        lat_cfg = 0; ret_fixed = 0; ready_pct = 60;
        for (int c = 0; c < 3000; c++) begin
            if (!in0_valid && $urandom_range(99, 0) < 50) begin
                in0_valid = 1'b1;
                in0_data  = DATA_W'($urandom);
            end
            if (!in1_valid && $urandom_range(99, 0) < 50) begin
                in1_valid = 1'b1;
                in1_data  = DATA_W'($urandom);
            end
            out0_ready = ($urandom_range(99, 0) < 60);
            step();
        end
        drain();
        check("rand_results_per_launch", delivered, launches);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ap_kernel_launcher.md
AP_KERNEL_LAUNCHER -- requirements
Module: ap_kernel_launcher

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of both argument channels.
REQ-002 SHALL have parameter RESULT_W, default 8, width of result channel.
REQ-003 SHALL provide the following ports; one clock; reset is asynchronous and active-low.
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous reset, active-low
- in0_data  input  DATA_W  argument 0 (dividend) token
- in0_valid / in0_ready  input / output  1  argument 0 handshake
- in1_data  input  DATA_W  argument 1 (divisor) token
- in1_valid / in1_ready  input / output  1  argument 1 handshake
- out0_data  output  RESULT_W  result token
- out0_valid / out0_ready  output / input  1  result handshake
- ap_start  output  1  launch request to block-level kernel
- ap_ready  input  1  kernel idle, accepts launch
- ap_done  input  1  one-cycle kernel completion pulse
- ap_arg0 / ap_arg1  output  DATA_W  argument values presented to kernel
- ap_ret  input  RESULT_W  kernel result, valid in ap_done cycle

Function
REQ-004 SHALL hold one slot per argument; a transfer occurs when valid && ready at a rising edge; the slot captures data and becomes full.
REQ-005 SHALL run FSM IDLE -> START -> RUN -> OUT -> IDLE.
REQ-006 IDLE: when both slots full at an edge, SHALL go to START; ap_start SHALL be high in START only.
REQ-007 START: SHALL hold ap_start high until ap_ready sampled high; on that edge, launch occurs, both slots SHALL empty, state -> RUN.
REQ-008 ap_arg0/ap_arg1 SHALL drive the slot contents and stay stable from START entry through the launch edge.
REQ-009 RUN: on ap_done high, SHALL capture ap_ret into the result register and go to OUT; ap_done outside RUN SHALL be ignored.
REQ-010 OUT: out0_valid SHALL be high and out0_data stable; on out0_valid && out0_ready, SHALL go to IDLE, or directly to START if both slots full.
REQ-011 Minimum latency: args accepted edge N -> ap_start high cycle N+1; ap_done cycle M -> out0_valid high cycle M+1.
REQ-012 Arguments SHALL be accepted in any order and on different cycles; a full slot SHALL deassert its ready (no overwrite).
REQ-013 in*_ready and out0_valid SHALL not depend combinationally on in*_valid or out0_ready.
REQ-014 Exactly one result SHALL be produced per launch; tokens SHALL never be dropped or duplicated.

Reset
REQ-015 rst low SHALL force, asynchronously: state IDLE, both slots empty, ap_start 0, out0_valid 0, data registers 0.
REQ-016 Reset mid-RUN SHALL discard the pending kernel result; a later stray ap_done SHALL be ignored.
REQ-017 in0_ready and in1_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-018 Macro AP_KERNEL_LAUNCHER_PREFETCH_EN SHALL select argument prefetch.
REQ-019 With macro defined: empty slots SHALL accept tokens in any state except during the START launch edge; the next launch's arguments can be collected during RUN/OUT.
REQ-020 Without macro: in*_ready SHALL be high only in IDLE with slot empty; slots fill only in IDLE.

Verification
REQ-021 Basic: in0=100, in1=7 same cycle; kernel ap_ready=1, ap_done 5 cycles after launch, ap_ret=14 -> ap_start exactly 1 cycle, ap_arg0=100, ap_arg1=7, out0_data=14 valid until taken.
REQ-022 Skewed args: in0=9 at cycle 2, in1=3 at cycle 6 -> ap_start first high cycle 7; in0_ready low cycles 3-7.
REQ-023 Kernel busy: ap_ready low 4 cycles -> ap_start held high 4+1 cycles, args stable, single launch.
REQ-024 Back-pressure: out0_ready low 10 cycles after result 0x2A -> out0_data=0x2A stable, no second launch; with PREFETCH_EN, next args 50/5 accepted during stall and ap_start high cycle after result taken.
REQ-025 Reset: rst low during RUN, then stray ap_done with ap_ret=0xFF -> out0_valid stays 0, next transaction 20/4 with ap_ret=5 yields 5.
